fifo_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream FIFO write port among num_ch_p upstream FIFOs. Each upstream FIFO presents a valid/yumi read interface. The downstream FIFO presents a ready/valid write interface. The arbiter grants one channel at a time, holds the grant for bursts of up to burst_p beats, and forwards the granted channel's data combinationally (zero latency). It sits between the per-row operand FIFOs and the shared feed FIFO of the systolic array.

---
 rtl/fifo_rr_arbiter.sv | 119 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin arbiter sharing one downstream FIFO write port
// among num_ch_p upstream valid/yumi FIFOs. A grant is held for bursts of up to
// burst_p beats. Data is forwarded combinationally from the granted channel.
module fifo_rr_arbiter #(
  parameter int width_p  = 8,
  parameter int num_ch_p = 4,
  parameter int burst_p  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [num_ch_p-1:0]           valid_i,
  input  logic [num_ch_p*width_p-1:0]   data_i,
  output logic [num_ch_p-1:0]           yumi_o,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [width_p-1:0]            data_o,
  output logic [num_ch_p-1:0]           grant_o,
  output logic                          lock_o
);

  localparam int CH_W  = $clog2(num_ch_p);
  localparam int CNT_W = $clog2(burst_p + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t               state_r;
  logic [CH_W-1:0]      ch_r;
  logic [CH_W-1:0]      last_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 w_found;
  logic [CH_W-1:0]      w_idx;
  logic [CH_W-1:0]      w_cand;
  int                   w_sum;
  logic [CH_W-1:0]      w_g;
  logic                 w_xfer;
  logic [num_ch_p-1:0]  w_onehot;
  logic [CNT_W-1:0]     w_cnt_nxt;

  // Rotating priority search: first valid channel after the last one served.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = 0;
    w_cand  = '0;
    for (int k = 1; k <= num_ch_p; k++) begin
      w_sum = int'(last_r) + k;
      if (w_sum >= num_ch_p) w_sum = w_sum - num_ch_p;
      w_cand = CH_W'(w_sum);
      if (!w_found && valid_i[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  // Output steering: the locked channel wins in LOCK, the search result in IDLE.
  always_comb begin
    w_g       = (state_r == LOCK) ? ch_r : w_idx;
    w_onehot  = '0;
    w_onehot[w_g] = 1'b1;
    if (state_r == LOCK) begin
      valid_o = valid_i[ch_r];
      grant_o = w_onehot;
    end else begin
      valid_o = w_found;
      grant_o = w_found ? w_onehot : '0;
    end
    lock_o    = (state_r == LOCK);
    w_xfer    = valid_o && ready_i;
    // A reset cycle must never dequeue from upstream.
    yumi_o    = (w_xfer && !reset_i) ? w_onehot : '0;
    data_o    = data_i[int'(w_g)*width_p +: width_p];
    w_cnt_nxt = cnt_r + CNT_W'(1);
  end

  // Arbitration state: burst lock, burst beat count and last-served channel.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ch_r    <= '0;
      last_r  <= CH_W'(num_ch_p - 1);
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (w_xfer) begin
            last_r <= w_g;
            // With single-beat bursts the grant rotates every transfer.
            if (burst_p > 1) begin
              state_r <= LOCK;
              ch_r    <= w_g;
              cnt_r   <= CNT_W'(1);
            end
          end
        end
        LOCK: begin
          if (!valid_i[ch_r]) begin
            // Locked channel ran dry: release early and re-arbitrate.
            state_r <= IDLE;
            cnt_r   <= '0;
          end else if (ready_i) begin
            if (w_cnt_nxt == CNT_W'(burst_p)) begin
              state_r <= IDLE;
              cnt_r   <= '0;
            end else begin
              cnt_r   <= w_cnt_nxt;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed, table-driven bench for fifo_rr_arbiter with
// burst_p=4, plus a hand-written rotation sequence on a burst_p=1 instance.
module tb_fifo_rr_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   vld;
  logic           rdy;
  logic [N*W-1:0] din;
  logic [N-1:0]   yumi;
  logic           vo;
  logic [W-1:0]   dout;
  logic [N-1:0]   gnt;
  logic           lock;

  logic           b_rst;
  logic [N-1:0]   b_vld;
  logic           b_rdy;
  logic [N-1:0]   b_yumi;
  logic           b_vo;
  logic [W-1:0]   b_dout;
  logic [N-1:0]   b_gnt;
  logic           b_lock;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic         rst;
    logic [N-1:0] vld;
    logic         rdy;
    logic         vo;
    logic [N-1:0] gnt;
    logic         lock;
    logic [N-1:0] yumi;
  } vec_t;

  vec_t vecs[$];

  fifo_rr_arbiter #(.width_p(W), .num_ch_p(N), .burst_p(4)) u_dut (
    .clk_i(clk), .reset_i(rst), .valid_i(vld), .data_i(din), .yumi_o(yumi),
    .ready_i(rdy), .valid_o(vo), .data_o(dout), .grant_o(gnt), .lock_o(lock)
  );

  fifo_rr_arbiter #(.width_p(W), .num_ch_p(N), .burst_p(1)) u_dut_b1 (
    .clk_i(clk), .reset_i(b_rst), .valid_i(b_vld), .data_i(din), .yumi_o(b_yumi),
    .ready_i(b_rdy), .valid_o(b_vo), .data_o(b_dout), .grant_o(b_gnt), .lock_o(b_lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [N-1:0] v, input logic rd,
                     input logic evo, input logic [N-1:0] eg, input logic el,
                     input logic [N-1:0] ey);
    vec_t t;
    t.rst = r; t.vld = v; t.rdy = rd; t.vo = evo; t.gnt = eg; t.lock = el; t.yumi = ey;
    vecs.push_back(t);
  endtask

  function automatic logic [W-1:0] chan_data(input logic [N-1:0] oh);
    logic [W-1:0] d;
    d = 'x;
    for (int k = 0; k < N; k++) if (oh[k]) d = 8'hA0 + W'(k);
    return d;
  endfunction

  initial begin
    din   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rst   = 1'b1; vld = '0; rdy = 1'b1;
    b_rst = 1'b1; b_vld = '0; b_rdy = 1'b1;

    // Reset state and fairness sweep: four 4-beat bursts ch0..ch3, then ch0.
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000);
    for (int c = 0; c < N; c++) begin
      add(0, 4'b1111, 1, 1, 4'(1 << c), 0, 4'(1 << c));
      for (int b = 0; b < 3; b++) add(0, 4'b1111, 1, 1, 4'(1 << c), 1, 4'(1 << c));
    end
    add(0, 4'b1111, 1, 1, 4'b0001, 0, 4'b0001);
    // Backpressure after beat 2 of ch0, then exactly two more ch0 beats, then ch1.
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 4'b0001);
    for (int b = 0; b < 3; b++) add(0, 4'b1111, 0, 1, 4'b0001, 1, 4'b0000);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 4'b0001);
    add(0, 4'b1111, 1, 1, 4'b0001, 1, 4'b0001);
    add(0, 4'b1111, 1, 1, 4'b0010, 0, 4'b0010);
    add(0, 4'b0000, 1, 0, 4'b0010, 1, 4'b0000);
    add(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000);
    // Early release: ch2 has two entries, then only ch1 is valid.
    add(0, 4'b0100, 1, 1, 4'b0100, 0, 4'b0100);
    add(0, 4'b0100, 1, 1, 4'b0100, 1, 4'b0100);
    add(0, 4'b0010, 1, 0, 4'b0100, 1, 4'b0000);
    add(0, 4'b0010, 1, 1, 4'b0010, 0, 4'b0010);
    add(0, 4'b0010, 1, 1, 4'b0010, 1, 4'b0010);
    add(0, 4'b0000, 1, 0, 4'b0010, 1, 4'b0000);
    // IDLE with ready low: grant re-evaluated each cycle, nothing taken.
    add(0, 4'b1101, 0, 1, 4'b0100, 0, 4'b0000);
    add(0, 4'b1001, 0, 1, 4'b1000, 0, 4'b0000);
    add(0, 4'b1001, 1, 1, 4'b1000, 0, 4'b1000);
    add(0, 4'b1001, 1, 1, 4'b1000, 1, 4'b1000);
    add(0, 4'b0000, 1, 0, 4'b1000, 1, 4'b0000);
    // Reset during beat 3 of a ch2 burst: no yumi, then ch0 first.
    add(0, 4'b0100, 1, 1, 4'b0100, 0, 4'b0100);
    add(0, 4'b0100, 1, 1, 4'b0100, 1, 4'b0100);
    add(1, 4'b0100, 1, 1, 4'b0100, 1, 4'b0000);
    add(0, 4'b1111, 1, 1, 4'b0001, 0, 4'b0001);
    add(0, 4'b0000, 1, 0, 4'b0001, 1, 4'b0000);
    // Ten idle cycles, then last-served channel (ch0) still has lowest priority.
    for (int i = 0; i < 10; i++) add(0, 4'b0000, 1, 0, 4'b0000, 0, 4'b0000);
    add(0, 4'b1111, 0, 1, 4'b0010, 0, 4'b0000);

    repeat (2) @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; vld = vecs[i].vld; rdy = vecs[i].rdy;
      #1;
      chk("valid_o", i, 32'(vo),   32'(vecs[i].vo));
      chk("grant_o", i, 32'(gnt),  32'(vecs[i].gnt));
      chk("lock_o",  i, 32'(lock), 32'(vecs[i].lock));
      chk("yumi_o",  i, 32'(yumi), 32'(vecs[i].yumi));
      if (vecs[i].vo) chk("data_o", i, 32'(dout), 32'(chan_data(vecs[i].gnt)));
      @(negedge clk);
    end

    // Single-beat bursts: grant rotates 0,1,2,3,0,... with no lock.
    b_rst = 1'b0; b_vld = 4'b1111; b_rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #1;
      chk("b1_grant_o", k, 32'(b_gnt),  32'(1 << (k % N)));
      chk("b1_yumi_o",  k, 32'(b_yumi), 32'(1 << (k % N)));
      chk("b1_lock_o",  k, 32'(b_lock), 32'(0));
      chk("b1_data_o",  k, 32'(b_dout), 32'(8'hA0 + (k % N)));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
